// File: rtl/vram_write_queue.sv
// rtl/vram_write_queue.sv - screen-window store filter and FIFO feeding the frame-buffer write port
module vram_write_queue #(
    parameter int          DEPTH        = 8,
    parameter logic [14:0] SCREEN_BASE  = 15'h4000,
    parameter int          SCREEN_WORDS = 8192,
    localparam int         AW           = $clog2(SCREEN_WORDS),
    localparam int         PW           = $clog2(DEPTH),
    localparam int         LW           = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          write_m,
    input  logic [14:0]   data_addr,
    input  logic [15:0]   out_m,
    output logic          vram_valid,
    input  logic          vram_ready,
    output logic [AW-1:0] vram_addr,
    output logic [15:0]   vram_data,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic [15:0]   drop_cnt,
    input  logic          clr_overflow
);

    localparam logic [15:0]   LIMIT      = {1'b0, SCREEN_BASE} + 16'(SCREEN_WORDS);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [AW-1:0] r_addr_mem [DEPTH];
    logic [15:0]   r_data_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic [15:0]   r_drop_cnt;

    logic          w_in_range;
    logic [AW-1:0] w_offset;
    logic [PW-1:0] w_newest;
    logic          w_full;
    logic          w_pop;
    logic          w_coalesce;
    logic          w_push;
    logic          w_drop;

    assign w_in_range = write_m && (data_addr >= SCREEN_BASE) && ({1'b0, data_addr} < LIMIT);
    assign w_offset   = AW'(data_addr - SCREEN_BASE);
    assign w_newest   = r_tail - PW'(1);
    assign w_full     = (r_level == FULL_LEVEL);
    assign w_pop      = vram_valid && vram_ready;

    // With two or more entries the newest one is never the head, so rewriting it in place
    // cannot disturb what is currently presented to the frame buffer.
    assign w_coalesce = w_in_range && (r_level >= LW'(2)) && (r_addr_mem[w_newest] == w_offset);
    assign w_push     = w_in_range && !w_coalesce && (!w_full || w_pop);
    assign w_drop     = w_in_range && !w_coalesce && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_push) begin
                r_addr_mem[r_tail] <= w_offset;
                r_data_mem[r_tail] <= out_m;
            end else if (w_coalesce) begin
                r_data_mem[w_newest] <= out_m;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_overflow) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Storage is never reset, so the outputs are gated to read 0 while the queue is empty.
    assign vram_valid = (r_level != '0);
    assign vram_addr  = vram_valid ? r_addr_mem[r_head] : '0;
    assign vram_data  = vram_valid ? r_data_mem[r_head] : '0;
    assign level      = r_level;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_vram_write_queue.sv
// tb/tb_vram_write_queue.sv - randomized and directed bench with a queue-based reference model
module tb_vram_write_queue;

    logic        clk;
    logic        reset;
    logic        write_m;
    logic [14:0] data_addr;
    logic [15:0] out_m;
    logic        vram_valid;
    logic        vram_ready;
    logic [12:0] vram_addr;
    logic [15:0] vram_data;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clr_overflow;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [12:0] a;
        logic [15:0] d;
    } ent_t;

    ent_t        m_q[$];
    logic        m_ovf;
    logic [15:0] m_cnt;

    vram_write_queue dut (
        .clk          (clk),
        .reset        (reset),
        .write_m      (write_m),
        .data_addr    (data_addr),
        .out_m        (out_m),
        .vram_valid   (vram_valid),
        .vram_ready   (vram_ready),
        .vram_addr    (vram_addr),
        .vram_data    (vram_data),
        .level        (level),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, take the edge, then advance the reference queue.
    task automatic tick(input bit w, input logic [14:0] a, input logic [15:0] d,
                        input bit rdy, input bit clr, input bit rst);
        bit          pop;
        bit          inr;
        bit          coal;
        bit          full;
        logic [12:0] off;
        ent_t        e;
        write_m = w; data_addr = a; out_m = d;
        vram_ready = rdy; clr_overflow = clr; reset = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cnt = '0;
        end else begin
            pop  = rdy && (m_q.size() != 0);
            inr  = w && (a >= 15'h4000) && (a < 15'h6000);
            off  = 13'(a - 15'h4000);
            coal = inr && (m_q.size() >= 2) && (m_q[m_q.size()-1].a == off);
            full = (m_q.size() == 8);
            if (coal) begin
                e = m_q[m_q.size()-1];
                e.d = d;
                m_q[m_q.size()-1] = e;
            end
            if (pop) void'(m_q.pop_front());
            if (clr) begin
                m_ovf = 1'b0;
                m_cnt = '0;
            end
            if (inr && !coal) begin
                if (!full || pop) begin
                    e.a = off; e.d = d;
                    m_q.push_back(e);
                end else if (!clr) begin
                    m_ovf = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end
        end
    endtask

    task automatic idle(input bit rdy);
        tick(1'b0, 15'h0, 16'h0, rdy, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        tick(1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 15'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        checks++; if (vram_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", vram_valid); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        checks++; if (vram_addr !== 13'd0 || vram_data !== 16'd0) begin
            errors++; $display("FAIL reset_outputs got addr=%h data=%h exp 0/0", vram_addr, vram_data);
        end
    endtask

    task automatic test_single;
        tick(1'b1, 15'h4005, 16'hABCD, 1'b1, 1'b0, 1'b0);
        checks++; if (vram_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", vram_valid); end
        checks++; if (vram_addr !== 13'd5 || vram_data !== 16'hABCD) begin
            errors++; $display("FAIL single_entry got addr=%h data=%h exp 0005/abcd", vram_addr, vram_data);
        end
        idle(1'b1);
        checks++; if (level !== 4'd0 || vram_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain got level=%0d valid=%0b exp 0/0", level, vram_valid);
        end
    endtask

    task automatic test_out_of_range;
        logic [14:0] addrs [3];
        addrs[0] = 15'h3FFF; addrs[1] = 15'h6000; addrs[2] = 15'h0010;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, addrs[i], 16'h1234, 1'b0, 1'b0, 1'b0);
            checks++; if (vram_valid !== 1'b0 || level !== 4'd0 || drop_cnt !== 16'd0) begin
                errors++; $display("FAIL oor_%h got valid=%0b level=%0d drops=%0d exp 0/0/0",
                                   addrs[i], vram_valid, level, drop_cnt);
            end
        end
        tick(1'b1, 15'h5FFF, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        checks++; if (vram_valid !== 1'b1 || vram_addr !== 13'h1FFF || vram_data !== 16'h0F0F) begin
            errors++; $display("FAIL top_of_window got valid=%0b addr=%h data=%h exp 1/1fff/0f0f",
                               vram_valid, vram_addr, vram_data);
        end
        idle(1'b1);
    endtask

    task automatic test_full;
        logic [12:0] exp_a;
        for (int i = 0; i < 8; i++) tick(1'b1, 15'h4000 + 15'(i), 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0);
        tick(1'b1, 15'h4100, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 16'd1) begin
            errors++; $display("FAIL full_drop got level=%0d ovf=%0b drops=%0d exp 8/1/1", level, overflow, drop_cnt);
        end
        tick(1'b1, 15'h4101, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        checks++; if (level !== 4'd8 || drop_cnt !== 16'd1) begin
            errors++; $display("FAIL full_push_pop got level=%0d drops=%0d exp 8/1", level, drop_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            exp_a = (i < 7) ? 13'(i + 1) : 13'h101;
            checks++; if (vram_valid !== 1'b1 || vram_addr !== exp_a) begin
                errors++; $display("FAIL full_drain_%0d got valid=%0b addr=%h exp 1/%h", i, vram_valid, vram_addr, exp_a);
            end
            idle(1'b1);
        end
        tick(1'b0, 15'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0 || level !== 4'd0) begin
            errors++; $display("FAIL full_clear got ovf=%0b drops=%0d level=%0d exp 0/0/0", overflow, drop_cnt, level);
        end
    endtask

    task automatic test_coalesce;
        tick(1'b1, 15'h4001, 16'd1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 15'h4002, 16'd2, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 15'h4002, 16'd3, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 4'd2) begin errors++; $display("FAIL coalesce_level got=%0d exp=2", level); end
        checks++; if (vram_addr !== 13'd1 || vram_data !== 16'd1) begin
            errors++; $display("FAIL coalesce_first got addr=%h data=%h exp 1/1", vram_addr, vram_data);
        end
        idle(1'b1);
        checks++; if (vram_addr !== 13'd2 || vram_data !== 16'd3) begin
            errors++; $display("FAIL coalesce_second got addr=%h data=%h exp 2/3", vram_addr, vram_data);
        end
        idle(1'b1);
    endtask

    task automatic test_no_coalesce_low;
        tick(1'b1, 15'h4001, 16'd7, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 15'h4001, 16'd8, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 4'd2 || vram_data !== 16'd7) begin
            errors++; $display("FAIL low_level_no_coalesce got level=%0d data=%0d exp 2/7", level, vram_data);
        end
        idle(1'b0);
        checks++; if (vram_valid !== 1'b1 || vram_data !== 16'd7) begin
            errors++; $display("FAIL hold_while_stalled got valid=%0b data=%0d exp 1/7", vram_valid, vram_data);
        end
        idle(1'b1);
        checks++; if (vram_data !== 16'd8) begin errors++; $display("FAIL low_second got=%0d exp=8", vram_data); end
        idle(1'b1);
    endtask

    task automatic test_clr_and_reset;
        for (int i = 0; i < 8; i++) tick(1'b1, 15'h4010 + 15'(i), 16'h2000 + 16'(i), 1'b0, 1'b0, 1'b0);
        tick(1'b1, 15'h4200, 16'h1, 1'b0, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0 || level !== 4'd8) begin
            errors++; $display("FAIL clr_wins got ovf=%0b drops=%0d level=%0d exp 0/0/8", overflow, drop_cnt, level);
        end
        tick(1'b1, 15'h4201, 16'h2, 1'b0, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin
            errors++; $display("FAIL drop_after_clr got ovf=%0b drops=%0d exp 1/1", overflow, drop_cnt);
        end
        tick(1'b1, 15'h4017, 16'h5555, 1'b0, 1'b0, 1'b0);
        checks++; if (drop_cnt !== 16'd1 || level !== 4'd8) begin
            errors++; $display("FAIL coalesce_when_full got drops=%0d level=%0d exp 1/8", drop_cnt, level);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL pre_reset_level got=%0d exp=5", level); end
        tick(1'b0, 15'h0, 16'h0, 1'b1, 1'b0, 1'b1);
        checks++; if (vram_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_reset got valid=%0b level=%0d ovf=%0b drops=%0d exp 0/0/0/0",
                               vram_valid, level, overflow, drop_cnt);
        end
    endtask

    task automatic test_random;
        int          rdy_pct;
        logic [14:0] a;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) rdy_pct = $urandom_range(5, 95);
            case ($urandom_range(0, 9))
                0: a = 15'($urandom_range(0, 32'h3FFF));
                1: a = 15'($urandom_range(32'h6000, 32'h7FFF));
                2: a = 15'h4000 + 15'($urandom_range(0, 8191));
                default: a = 15'h4000 + 15'($urandom_range(0, 3));
            endcase
            tick($urandom_range(0, 9) < 7, a, 16'($urandom), $urandom_range(0, 99) < rdy_pct,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 299) == 0);
            checks++; if (level !== 4'(m_q.size()) || vram_valid !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rand_level n=%0d got level=%0d valid=%0b exp level=%0d", n, level, vram_valid, m_q.size());
            end
            checks++; if (overflow !== m_ovf || drop_cnt !== m_cnt) begin
                errors++; $display("FAIL rand_drops n=%0d got ovf=%0b drops=%0d exp %0b/%0d", n, overflow, drop_cnt, m_ovf, m_cnt);
            end
            if (m_q.size() != 0) begin
                checks++; if (vram_addr !== m_q[0].a || vram_data !== m_q[0].d) begin
                    errors++; $display("FAIL rand_head n=%0d got addr=%h data=%h exp %h/%h",
                                       n, vram_addr, vram_data, m_q[0].a, m_q[0].d);
                end
            end
        end
    endtask

    initial begin
        write_m = 1'b0; data_addr = '0; out_m = '0;
        vram_ready = 1'b0; clr_overflow = 1'b0; reset = 1'b1;
        m_ovf = 1'b0; m_cnt = '0;
        test_reset();
        test_single();
        test_out_of_range();
        test_full();
        test_coalesce();
        test_no_coalesce_low();
        test_clr_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
